// File: rtl/motor_sched_pkg.sv
// Shared constants, FSM state type and BCD conversion for the motor step scheduler.
package motor_sched_pkg;

  localparam int NUM_MOTORS = 6;
  localparam int POS_W = 10;
  localparam logic [2:0] NO_MOTOR = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    STEP,
    WAIT
  } state_t;

  // Three BCD digits (tens, units, tenths) to a 0-999 step count.
  function automatic logic [POS_W-1:0] bcd3_to_bin(input logic [3:0] d0,
                                                   input logic [3:0] d1,
                                                   input logic [3:0] d2);
    logic [POS_W-1:0] r;
    r = ({6'd0, d0} * 10'd100) + ({6'd0, d1} * 10'd10) + {6'd0, d2};
    return r;
  endfunction

endpackage

// File: rtl/motor_step_scheduler_pick.sv
// Combinational round-robin picker: first pending motor after ptr, wrapping 5 -> 0.
module motor_rr_pick
  import motor_sched_pkg::*;
(
  input  logic [NUM_MOTORS-1:0] pending,
  input  logic [2:0]            ptr,
  output logic [2:0]            grant,
  output logic                  found
);

  logic [2:0]            cand [NUM_MOTORS];
  logic [NUM_MOTORS-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MOTORS; gi++) begin : g_cand
      logic [3:0] sum;
      assign sum      = {1'b0, ptr} + 4'(gi + 1);
      assign cand[gi] = (sum >= 4'(NUM_MOTORS)) ? 3'(sum - 4'(NUM_MOTORS)) : sum[2:0];
      assign hit[gi]  = pending[cand[gi]];
    end
  endgenerate

  // Lowest offset with a pending motor wins (scan from the far end so it overwrites last).
  always_comb begin
    grant = NO_MOTOR;
    found = 1'b0;
    for (int k = NUM_MOTORS - 1; k >= 0; k--) begin
      if (hit[k]) begin
        grant = cand[k];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/motor_step_scheduler.sv
// Six-motor step scheduler: BCD setpoint intake, target/position tables and a
// shared step generator granted to pending motors in round-robin bursts.
// Optional soft travel limit clamping enabled by defining MOTOR_SCHED_LIMIT_EN.
module motor_step_scheduler
  import motor_sched_pkg::*;
#(
  parameter int STEP_DIV = 8,
  parameter int BURST    = 4,
  parameter int LIMIT    = 900
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_motor,
  input  logic [3:0]        cmd_d0,
  input  logic [3:0]        cmd_d1,
  input  logic [3:0]        cmd_d2,
  output logic              cmd_err,
  output logic              cmd_clamped,
  input  logic [2:0]        rd_motor,
  output logic [POS_W-1:0]  rd_pos,
  output logic [NUM_MOTORS-1:0] step,
  output logic              dir,
  output logic              busy,
  output logic [2:0]        active_motor,
  output logic              arrive
);

  localparam int WAIT_W  = $clog2(STEP_DIV);
  localparam int BURST_W = $clog2(BURST + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LOAD = WAIT_W'(STEP_DIV - 2);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST);

  if (STEP_DIV < 2 || BURST < 1 || LIMIT < 0 || LIMIT > 999) begin : g_param_check
    $error("motor_step_scheduler: illegal parameter value");
  end

  logic [POS_W-1:0]      target_reg [NUM_MOTORS];
  logic [POS_W-1:0]      pos_reg    [NUM_MOTORS];
  logic [NUM_MOTORS-1:0] pending;

  state_t               state_reg, state_next;
  logic [2:0]           rr_reg, active_reg;
  logic [BURST_W-1:0]   burst_reg;
  logic [WAIT_W-1:0]    wait_reg;
  logic                 arrive_reg, cmd_err_reg, cmd_clamped_reg;
  logic [POS_W-1:0]     rd_pos_reg;

  logic [2:0]           pick_grant;
  logic                 pick_found;
  logic [POS_W-1:0]     act_pos, act_tgt, act_pos_next;
  logic                 act_pending, act_up, fire, keep_going;
  logic                 cmd_bad;
  logic [POS_W-1:0]     cmd_value, cmd_store;

  // ---------------- command decode ----------------
  assign cmd_bad   = (cmd_motor > 3'd5) || (cmd_d0 > 4'd9) || (cmd_d1 > 4'd9) || (cmd_d2 > 4'd9);
  assign cmd_value = bcd3_to_bin(cmd_d0, cmd_d1, cmd_d2);

`ifdef MOTOR_SCHED_LIMIT_EN
  localparam logic [POS_W-1:0] LIMIT_STEPS = POS_W'(LIMIT);
  logic cmd_over;
  assign cmd_over  = cmd_value > LIMIT_STEPS;
  assign cmd_store = cmd_over ? LIMIT_STEPS : cmd_value;

  // Clamp notification, suppressed when the command is rejected outright.
  always_ff @(posedge clk) begin
    if (rst) cmd_clamped_reg <= 1'b0;
    else     cmd_clamped_reg <= cmd_valid && !cmd_bad && cmd_over;
  end
`else
  assign cmd_store = cmd_value;

  // No clamping in this build; the flag never rises.
  always_ff @(posedge clk) begin
    cmd_clamped_reg <= 1'b0;
  end
`endif

  // Rejection pulse one cycle after the offending commit.
  always_ff @(posedge clk) begin
    if (rst) cmd_err_reg <= 1'b0;
    else     cmd_err_reg <= cmd_valid && cmd_bad;
  end

  // ---------------- active-motor view ----------------
  assign act_pos      = (active_reg < 3'd6) ? pos_reg[active_reg]    : '0;
  assign act_tgt      = (active_reg < 3'd6) ? target_reg[active_reg] : '0;
  assign act_pending  = act_pos != act_tgt;
  assign act_up       = act_tgt > act_pos;
  assign act_pos_next = act_up ? act_pos + 10'd1 : act_pos - 10'd1;
  assign fire         = (state_reg == STEP) && act_pending;
  assign keep_going   = (burst_reg < BURST_MAX) && act_pending;

  // ---------------- per-motor tables ----------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MOTORS; gi++) begin : g_motor
      assign pending[gi] = pos_reg[gi] != target_reg[gi];
      assign step[gi]    = fire && (active_reg == 3'(gi));

      // Target written by commits; position moves one step toward target when fired.
      always_ff @(posedge clk) begin
        if (rst) begin
          target_reg[gi] <= '0;
          pos_reg[gi]    <= '0;
        end else begin
          if (cmd_valid && !cmd_bad && (cmd_motor == 3'(gi))) target_reg[gi] <= cmd_store;
          if (fire && (active_reg == 3'(gi))) pos_reg[gi] <= act_pos_next;
        end
      end
    end
  endgenerate

  motor_rr_pick u_pick (
    .pending (pending),
    .ptr     (rr_reg),
    .grant   (pick_grant),
    .found   (pick_found)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|pending) state_next = SELECT;
      SELECT:  state_next = pick_found ? STEP : IDLE;
      STEP:    state_next = act_pending ? WAIT : IDLE;
      WAIT:    if (wait_reg == '0) state_next = keep_going ? STEP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant, burst count, step-period timer and arrival pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_reg     <= 3'd5;
      active_reg <= NO_MOTOR;
      burst_reg  <= '0;
      wait_reg   <= '0;
      arrive_reg <= 1'b0;
    end else begin
      arrive_reg <= 1'b0;
      case (state_reg)
        SELECT: begin
          if (pick_found) begin
            active_reg <= pick_grant;
            rr_reg     <= pick_grant;
            burst_reg  <= '0;
          end
        end
        STEP: begin
          if (act_pending) begin
            burst_reg  <= burst_reg + 1'b1;
            wait_reg   <= WAIT_LOAD;
            arrive_reg <= act_pos_next == act_tgt;
          end else begin
            active_reg <= NO_MOTOR;
          end
        end
        WAIT: begin
          if (wait_reg != '0) wait_reg <= wait_reg - 1'b1;
          else if (!keep_going) active_reg <= NO_MOTOR;
        end
        default: ;
      endcase
    end
  end

  // Registered position readback.
  always_ff @(posedge clk) begin
    if (rst)                  rd_pos_reg <= '0;
    else if (rd_motor < 3'd6) rd_pos_reg <= pos_reg[rd_motor];
    else                      rd_pos_reg <= '0;
  end

  assign dir          = fire && act_up;
  assign busy         = state_reg != IDLE;
  assign active_motor = active_reg;
  assign arrive       = arrive_reg;
  assign cmd_err      = cmd_err_reg;
  assign cmd_clamped  = cmd_clamped_reg;
  assign rd_pos       = rd_pos_reg;

endmodule

// File: tb/tb_motor_step_scheduler.sv
// Bench for motor_step_scheduler: timeline model of the scheduler checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_motor_step_scheduler;

  localparam int STEP_DIV = 8;
  localparam int BURST    = 4;
  localparam int LIMIT    = 900;
`ifdef MOTOR_SCHED_LIMIT_EN
  localparam int LIM_EN = 1;
`else
  localparam int LIM_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [2:0] cmd_motor;
  logic [3:0] cmd_d0, cmd_d1, cmd_d2;
  logic       cmd_err, cmd_clamped;
  logic [2:0] rd_motor;
  logic [9:0] rd_pos;
  logic [5:0] step;
  logic       dir, busy, arrive;
  logic [2:0] active_motor;

  motor_step_scheduler #(.STEP_DIV(STEP_DIV), .BURST(BURST), .LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_motor(cmd_motor),
    .cmd_d0(cmd_d0), .cmd_d1(cmd_d1), .cmd_d2(cmd_d2),
    .cmd_err(cmd_err), .cmd_clamped(cmd_clamped),
    .rd_motor(rd_motor), .rd_pos(rd_pos), .step(step), .dir(dir),
    .busy(busy), .active_motor(active_motor), .arrive(arrive)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  int m_tgt [6];
  int m_pos [6];
  int m_rr;
  int e_step, e_dir, e_busy, e_active, e_arrive, e_err, e_clamp, e_rd;
  bit rst_hit;
  int g, burst, old_t, v;
  bit p, cont, d;

  function automatic bit any_pending();
    for (int i = 0; i < 6; i++) if (m_pos[i] != m_tgt[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick();
    for (int k = 1; k <= 6; k++) if (m_pos[(m_rr + k) % 6] != m_tgt[(m_rr + k) % 6]) return (m_rr + k) % 6;
    return -1;
  endfunction

  // One clock edge: apply reset or an incoming command to the model tables.
  task automatic tick();
    @(posedge clk);
    e_rd = (rd_motor < 6) ? m_pos[rd_motor] : 0;
    e_err = 0; e_clamp = 0; e_arrive = 0; e_step = 0; e_dir = 0;
    rst_hit = rst;
    if (rst) begin
      for (int i = 0; i < 6; i++) begin m_tgt[i] = 0; m_pos[i] = 0; end
      m_rr = 5;
      e_rd = 0;
    end else if (cmd_valid) begin
      if (cmd_motor > 5 || cmd_d0 > 9 || cmd_d1 > 9 || cmd_d2 > 9) e_err = 1;
      else begin
        v = cmd_d0 * 100 + cmd_d1 * 10 + cmd_d2;
        if (LIM_EN != 0 && v > LIMIT) begin v = LIMIT; e_clamp = 1; end
        m_tgt[cmd_motor] = v;
      end
    end
  endtask

  task automatic set_out(input int b, input int a);
    e_busy = b; e_active = a;
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin m_tgt[i] = 0; m_pos[i] = 0; end
    m_rr = 5;
    e_step = 0; e_dir = 0; e_arrive = 0; e_err = 0; e_clamp = 0; e_rd = 0;
    forever begin
      set_out(0, 7);                      // idle
      p = any_pending();
      tick();
      if (rst_hit || !p) continue;
      set_out(1, 7);                      // arbitration cycle
      g = pick();
      tick();
      if (rst_hit || g < 0) continue;
      m_rr = g;
      burst = 0;
      forever begin
        set_out(1, g);
        if (m_pos[g] == m_tgt[g]) begin tick(); break; end
        d = m_tgt[g] > m_pos[g];
        e_step = 1 << g; e_dir = d; old_t = m_tgt[g];
        tick();
        if (rst_hit) break;
        m_pos[g] = d ? m_pos[g] + 1 : m_pos[g] - 1;
        burst++;
        e_arrive = (m_pos[g] == old_t);
        cont = 0;
        for (int w = 0; w < STEP_DIV - 1; w++) begin
          if (w == STEP_DIV - 2) cont = (burst < BURST) && (m_pos[g] != m_tgt[g]);
          tick();
          if (rst_hit) break;
        end
        if (rst_hit || !cont) break;
      end
    end
  end

  // ---------------- per-cycle compare and event logs ----------------
  int p_cyc[$], p_mot[$], p_dir[$], a_cyc[$], a_mot[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("step", int'(step), e_step);
      if (e_step != 0) check("dir", int'(dir), e_dir);
      check("busy", int'(busy), e_busy);
      check("active_motor", int'(active_motor), e_active);
      check("arrive", int'(arrive), e_arrive);
      check("cmd_err", int'(cmd_err), e_err);
      check("cmd_clamped", int'(cmd_clamped), e_clamp);
      check("rd_pos", int'(rd_pos), e_rd);
      if (step != 0) begin
        for (int i = 0; i < 6; i++) if (step[i]) p_mot.push_back(i);
        p_cyc.push_back(cyc);
        p_dir.push_back(int'(dir));
      end
      if (arrive) begin
        a_cyc.push_back(cyc);
        a_mot.push_back(int'(active_motor));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int t_cmd;

  task automatic clear_logs();
    p_cyc.delete(); p_mot.delete(); p_dir.delete(); a_cyc.delete(); a_mot.delete();
  endtask

  task automatic cmd_on(input int m, input int a, input int b, input int c);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_motor = 3'(m); cmd_d0 = 4'(a); cmd_d1 = 4'(b); cmd_d2 = 4'(c);
    t_cmd = cyc;
    $display("cmd cycle=%0d motor=%0d digits=%0d,%0d,%0d", cyc, m, a, b, c);
  endtask

  task automatic cmd_off();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int quiet = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      quiet = busy ? 0 : quiet + 1;
      if (quiet >= 4) return;
    end
    check({name, "_timeout"}, 1, 0);
  endtask

  task automatic read_pos(input int m, output int val);
    @(negedge clk); rd_motor = 3'(m);
    @(negedge clk); val = int'(rd_pos);
  endtask

  int rv;
  int bm[$], bc[$];
  int exp_m[5] = '{0, 1, 0, 1, 0};
  int exp_c[5] = '{4, 4, 4, 1, 2};

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_motor = '0; cmd_d0 = '0; cmd_d1 = '0; cmd_d2 = '0; rd_motor = '0;
    @(negedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", int'(busy), 0);
    check("reset_active", int'(active_motor), 7);
    check("reset_step", int'(step), 0);
    check("reset_rd_pos", int'(rd_pos), 0);

    // Motor 2 -> 0.3: three upward pulses spaced STEP_DIV, then arrive.
    clear_logs();
    cmd_on(2, 0, 0, 3); cmd_off();
    wait_quiet(300, "t1");
    check("t1_pulses", p_cyc.size(), 3);
    if (p_cyc.size() == 3) begin
      check("t1_first_latency", p_cyc[0] - t_cmd, 3);
      check("t1_gap1", p_cyc[1] - p_cyc[0], STEP_DIV);
      check("t1_gap2", p_cyc[2] - p_cyc[1], STEP_DIV);
      check("t1_motor", p_mot[2], 2);
      check("t1_dir", p_dir[0] + p_dir[1] + p_dir[2], 3);
    end
    check("t1_arrivals", a_cyc.size(), 1);
    if (a_cyc.size() == 1 && p_cyc.size() == 3) begin
      check("t1_arrive_cycle", a_cyc[0], p_cyc[2] + 1);
      check("t1_arrive_motor", a_mot[0], 2);
    end
    read_pos(2, rv); check("t1_rd_pos2", rv, 3);

    // Two motors sharing the generator in bursts.
    do_reset();
    clear_logs();
    cmd_on(0, 0, 1, 0); cmd_on(1, 0, 0, 5); cmd_off();
    wait_quiet(2000, "t2");
    bm.delete(); bc.delete();
    for (int i = 0; i < p_mot.size(); i++) begin
      if (i == 0 || p_mot[i] != p_mot[i-1]) begin bm.push_back(p_mot[i]); bc.push_back(1); end
      else bc[bc.size()-1] = bc[bc.size()-1] + 1;
    end
    check("t2_bursts", bm.size(), 5);
    if (bm.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("t2_burst%0d_motor", i), bm[i], exp_m[i]);
        check($sformatf("t2_burst%0d_len", i), bc[i], exp_c[i]);
      end
    end
    check("t2_arrivals", a_mot.size(), 2);
    read_pos(0, rv); check("t2_rd_pos0", rv, 10);
    read_pos(1, rv); check("t2_rd_pos1", rv, 5);

    // Motor 3 up to 6, then back down to 2.
    cmd_on(3, 0, 0, 6); cmd_off();
    wait_quiet(300, "t3a");
    clear_logs();
    cmd_on(3, 0, 0, 2); cmd_off();
    wait_quiet(300, "t3b");
    check("t3_pulses", p_cyc.size(), 4);
    if (p_cyc.size() == 4) begin
      check("t3_dir_sum", p_dir[0] + p_dir[1] + p_dir[2] + p_dir[3], 0);
      check("t3_motor", p_mot[3], 3);
    end
    read_pos(3, rv); check("t3_rd_pos3", rv, 2);

    // Rejected commands.
    clear_logs();
    cmd_on(6, 0, 0, 1); cmd_off();
    check("err_motor6", int'(cmd_err), 1);
    cmd_on(1, 0, 4'hA, 0); cmd_off();
    check("err_digit", int'(cmd_err), 1);
    wait_quiet(50, "err");
    check("err_no_pulses", p_cyc.size(), 0);
    read_pos(1, rv); check("err_rd_pos1", rv, 5);

    // Reset in the middle of a burst on motor 4.
    clear_logs();
    cmd_on(4, 0, 2, 0); cmd_off();
    for (int n = 0; n < 200 && p_cyc.size() < 3; n++) @(negedge clk);
    check("rst_burst_started", int'(p_cyc.size() >= 3), 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst_step", int'(step), 0);
    check("rst_busy", int'(busy), 0);
    read_pos(4, rv); check("rst_rd_pos4", rv, 0);
    read_pos(0, rv); check("rst_rd_pos0", rv, 0);

    // Setpoint 95.0 against the soft limit.
    cmd_on(5, 9, 5, 0); cmd_off();
    check("lim_clamped", int'(cmd_clamped), LIM_EN);
    wait_quiet(12000, "lim");
    read_pos(5, rv); check("lim_rd_pos5", rv, (LIM_EN != 0) ? 900 : 950);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/motor_step_scheduler.md
# motor_step_scheduler

Sequences the six-motor positioning datapath from committed operator setpoints. Stores a per-motor target (three BCD digits, 00.0–99.9, converted to a 0–999 step count) and a per-motor current position. Shares a single step-pulse generator among motors that have not reached their target, using round-robin bursts. Sits between the operator input block (motor number, BCD value, commit) and the motor driver step/direction pins.

## Interface
Parameters:
- STEP_DIV, 8: step period in clk cycles; legal values ≥ 2.
- BURST, 4: maximum steps per grant before re-arbitration; legal values ≥ 1.
- LIMIT, 900: soft travel limit in steps; used only with MOTOR_SCHED_LIMIT_EN.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  single-cycle commit strobe.
- cmd_motor  in  3  target motor, 0–5.
- cmd_d0  in  4  tens digit (BCD).
- cmd_d1  in  4  units digit (BCD).
- cmd_d2  in  4  tenths digit (BCD).
- cmd_err  out  1  one-cycle pulse: command rejected.
- cmd_clamped  out  1  one-cycle pulse: target clamped to LIMIT. Tied 0 without the macro.
- rd_motor  in  3  position readback select.
- rd_pos  out  10  registered position of rd_motor; 1-cycle latency; 0 when rd_motor > 5.
- step  out  6  one-hot step pulse, one bit per motor.
- dir  out  1  1 = increment position, 0 = decrement; valid while any step bit is high.
- busy  out  1  high whenever the state is not IDLE.
- active_motor  out  3  motor currently granted; 3'b111 when no motor is granted.
- arrive  out  1  one-cycle pulse when the active motor reaches its target; pairs with active_motor.

## Operation
Reset:
- target[0..5] = 0, pos[0..5] = 0, rr pointer = 5, state = IDLE.
- All outputs are 0, except active_motor = 3'b111.

Command intake:
- Always accepted; there is no ready signal.
- Reject when cmd_motor > 5 or any digit > 9: cmd_err pulses in the next cycle and the target table is unchanged.
- Otherwise target[cmd_motor] = d0*100 + d1*10 + d2 (10 bits), written at the edge that samples cmd_valid.
- A command to the active motor takes effect at its next step decision. Direction is re-evaluated every step.

Pending:
- Motor m is pending when pos[m] != target[m].

State machine:
- IDLE: if any motor is pending → SELECT.
- SELECT (1 cycle):
  - Grant the first pending motor searching from rr+1 modulo 6, wrapping 5→0.
  - Set rr = granted motor and clear the burst count.
  - If no motor is pending (target rewritten meanwhile) → IDLE; otherwise → STEP.
- STEP (1 cycle):
  - step[active] = 1; dir = (target > pos).
  - At the end of the cycle, pos steps ±1 and the burst count increments.
  - If the new pos equals target, arrive pulses in the following cycle.
- WAIT (STEP_DIV-1 cycles):
  - Stay in STEP when burst count < BURST and pos != target.
  - Otherwise → IDLE, with active_motor = 3'b111.
  - If the target equals pos when STEP is entered (rewritten during WAIT), emit no pulse and go → IDLE.

Arithmetic:
- pos stays within 0–999 by construction, because a step always moves toward target.

## Timing
- cmd_valid in cycle t → target visible in t+1 → SELECT in t+2 → first step pulse in t+3.
- Pulse spacing within a burst is exactly STEP_DIV cycles.
- Gap between bursts: WAIT end → IDLE (1 cycle) → SELECT (1 cycle) → STEP.
- Simultaneous command and step on the same motor: the step uses the old target; the new target applies from the next decision.
- A rst asserted mid-burst forces step = 0 in the following cycle and clears the position table.
- cmd_err and cmd_clamped each appear one cycle after cmd_valid.

## Configuration
- MOTOR_SCHED_LIMIT_EN defined:
  - A converted value above LIMIT is stored as LIMIT.
  - cmd_clamped pulses one cycle after cmd_valid.
  - cmd_err takes priority over clamping.
- Macro undefined:
  - No clamping; cmd_clamped is tied 0.
  - LIMIT is unused.

## Structure
- Package motor_sched_pkg:
  - NUM_MOTORS = 6, POS_W = 10, NO_MOTOR = 3'b111.
  - State enum: IDLE, SELECT, STEP, WAIT.
  - Function bcd3_to_bin.
- Sub-module motor_rr_pick: combinational round-robin picker.
  - Inputs: 6-bit pending vector and 3-bit pointer.
  - Outputs: grant index and found flag.

## Test plan
- Command motor 2 = 0,0,3 at cycle t → step[2] pulses at t+3, t+3+STEP_DIV and t+3+2·STEP_DIV with dir=1; arrive pulses with active_motor=2; rd_pos(2)=3.
- Command motor 0 = 0,1,0 and motor 1 = 0,0,5 in back-to-back cycles, BURST=4 → grant order 0(4 steps), 1(4), 0(4), 1(1), 0(2); both arrive.
- Motor 3 at pos 6, command 0,0,2 → four pulses with dir=0; final rd_pos(3)=2.
- cmd_motor=6, or cmd_d1=4'hA → cmd_err pulse; target table unchanged; no step pulses.
- Assert rst during a burst on motor 4 → step=0 the next cycle; busy=0; rd_pos(4)=0.
- With MOTOR_SCHED_LIMIT_EN and LIMIT=900: command 9,5,0 → cmd_clamped pulse; motor settles at rd_pos=900. Without the macro: settles at 950 and cmd_clamped stays 0.
